// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked ALU with iterative multi-bit shifts; optional carry flag via ALU_ITER_CARRY_CHAIN_EN
module alu_iter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             xy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [SHAMT_W-1:0] C_ONE = SHAMT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic               r_cout;
    logic [SHAMT_W-1:0] r_cnt;
    logic [2:0]         r_sop;

    logic               w_c;
    logic [SHAMT_W-1:0] w_n;
    logic [WIDTH-1:0]   w_bop;
    logic               w_cadd;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_lq;
    logic               w_lc;
    logic               w_fill;
    logic [WIDTH-1:0]   w_sq;
    logic               w_sc;

`ifdef ALU_ITER_CARRY_CHAIN_EN
    logic r_cflag;
    logic w_unused_cin;
    assign w_unused_cin = cin;
    assign w_c          = r_cflag;

    // carry flag follows cout of every consumed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cflag <= 1'b0;
        end else if (r_state == S_DONE && out_ready) begin
            r_cflag <= r_cout;
        end
    end
`else
    assign w_c = cin;
`endif

    assign w_n       = b[SHAMT_W-1:0];
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign q         = r_q;
    assign cout      = r_cout;

    // single-cycle ops 0-7: logic ops and the four add/subtract flavours
    always_comb begin
        w_bop  = op[1] ? ~b : b;
        w_cadd = 1'b0;
        case (op[1:0])
            2'b00:   w_cadd = 1'b0;
            2'b10:   w_cadd = 1'b1;
            default: w_cadd = w_c;
        endcase
        w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cadd};
        w_lq  = w_sum[WIDTH-1:0];
        w_lc  = w_sum[WIDTH];
        case (op[2:0])
            3'd0:    begin w_lq = b;     w_lc = xy;          end
            3'd1:    begin w_lq = a | b; w_lc = w_c ^ xy;    end
            3'd2:    begin w_lq = a & b; w_lc = (|a) ^ xy;   end
            3'd3:    begin w_lq = a ^ b; w_lc = (^a) ^ xy;   end
            default: begin w_lq = w_sum[WIDTH-1:0]; w_lc = w_sum[WIDTH]; end
        endcase
    end

    // one 1-bit shift step; left and right groups share the same fill selection
    always_comb begin
        w_fill = 1'b0;
        case (r_sop[1:0])
            2'd0:    w_fill = 1'b0;
            2'd1:    w_fill = r_cout;
            2'd2:    w_fill = r_q[0];
            default: w_fill = r_q[WIDTH-1];
        endcase
        if (!r_sop[2]) begin
            w_sq = {r_q[WIDTH-2:0], w_fill};
            w_sc = r_q[WIDTH-1];
        end else begin
            w_sq = {w_fill, r_q[WIDTH-1:1]};
            w_sc = r_q[0];
        end
    end

    // control FSM; r_cout doubles as the running carry during SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_sop   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sop <= op[2:0];
                        if (!op[3]) begin
                            r_q     <= w_lq;
                            r_cout  <= w_lc;
                            r_state <= S_DONE;
                        end else begin
                            r_q    <= a;
                            r_cout <= w_c;
                            r_cnt  <= w_n;
                            r_state <= (w_n == '0) ? S_DONE : S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_q    <= w_sq;
                    r_cout <= w_sc;
                    r_cnt  <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the 8-bit combinational ALU. Keeps the same 16-op encoding, `xy` carry-invert input and `cin`/`cout` carry semantics, generalised to `WIDTH` bits. The eight shift/rotate ops (8–F) become multi-bit shifts by a run-time count, executed iteratively one bit per cycle. It sits between the register file read stage and writeback, with valid/ready on both sides so the sequencer can stall on multi-cycle shifts.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; must be ≥ 2.
- `SHAMT_W`, default `$clog2(WIDTH)`: width of the shift-count field taken from `b`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high only in IDLE.
- `op`  in  4  operation code, same encoding as the 8-bit ALU.
- `a`, `b`  in  WIDTH  operands. For ops 8–F, `b[SHAMT_W-1:0]` is the shift count N.
- `cin`  in  1  carry in.
- `xy`  in  1  carry-out invert/select, same meaning as the 8-bit ALU.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed.
- `q`  out  WIDTH  registered result.
- `cout`  out  1  registered carry out.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - SHIFT: N steps remain.
  - DONE: `out_valid`=1.
- **Accept.** An operation is accepted on `in_valid & in_ready`. At the accepting edge, `op`, `a`, `b`, `xy` and the effective carry c are latched.
- **Ops 0–7** complete at the accepting edge; the FSM goes IDLE→DONE:
  - 0: q=b, cout=xy.
  - 1: q=a|b, cout=c^xy.
  - 2: q=a&b, cout=(a≠0)^xy.
  - 3: q=a^b, cout=^a ^ xy.
  - 4: {cout,q}=a+b.
  - 5: {cout,q}=a+b+c.
  - 6: {cout,q}=a+~b+1.
  - 7: {cout,q}=a+~b+c.
  - Sums are WIDTH+1 bits wide; `~b` is masked to WIDTH bits.
- **Ops 8–F with N=0:** q=a, cout=c; the FSM goes IDLE→DONE.
- **Ops 8–F with N>0:** the working register is loaded with a and running carry r=c; the FSM goes IDLE→SHIFT.
- **Each SHIFT edge** performs one 1-bit step:
  - r becomes the bit shifted out.
  - The count decrements.
  - After the Nth step the FSM goes to DONE.
- **Fill bit per step:**
  - 8: shift left, fill 0.
  - 9: shift left, fill r (rotate left through carry, WIDTH+1 bits).
  - A: shift left, fill current q[0].
  - B: rotate left (fill q[WIDTH-1]).
  - C: shift right, fill 0.
  - D: shift right, fill r (rotate right through carry).
  - E: rotate right (fill q[0]).
  - F: arithmetic shift right (fill q[WIDTH-1]).
- **Shift carry out:** cout = final r, which is the last bit shifted out. `xy` is ignored for ops 8–F.
- **DONE:** q and cout are held stable until `out_valid & out_ready`, then the FSM returns to IDLE.
- **No overlap:** a new operation cannot be accepted in the same cycle a result is consumed.
- **Reset:** asserting `rst_n`=0 at any time, including mid-SHIFT, immediately forces IDLE, q=0, cout=0, `out_valid`=0, and the carry flag to 0. The in-flight operation is discarded.
- **Output validity:** q may show intermediate values during SHIFT; it is defined only while `out_valid`=1.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, q=0, cout=0.
- **Ops 0–7, or N=0:** accepted in cycle k, so `out_valid`=1 in cycle k+1.
- **Shift with count N:** accepted in cycle k, so `out_valid`=1 in cycle k+1+N. The maximum is WIDTH cycles (N=WIDTH-1).
- **Throughput:** at most one operation per 2 cycles (accept, then DONE with `out_ready`=1).
- `in_ready` is a pure function of state: IDLE only.

## Configuration
- Macro: `ALU_ITER_CARRY_CHAIN_EN`.
- **Defined:**
  - The effective carry c is an internal carry flag, not the `cin` port; `cin` is ignored.
  - The flag is updated to `cout` on each result handshake.
  - It resets to 0.
- **Undefined:** c is `cin`, sampled at accept. No flag register exists.

## Test plan
- **Add with carry out** (WIDTH=8): op4, a=0xFF, b=0x01 → q=0x00, cout=1, `out_valid` exactly 1 cycle after accept.
- **Subtract:** op6, a=0x05, b=0x07 → q=0xFE, cout=0.
- **Rotate right through carry:** op D, a=0x01, b=0x03, cin=1 (macro off) → q=0x60, cout=0, `out_valid` 4 cycles after accept, `in_ready`=0 throughout.
- **Arithmetic shift right:** op F, a=0x80, b=0x07 → q=0xFF, cout=0. Then op 8, a=0x81, b=0x00, cin=1 → q=0x81, cout=1.
- **Carry chain and backpressure:** op4, 0xFF+0x01, then op5, 0x00+0x00, with cin=0 → q=0x01 with `ALU_ITER_CARRY_CHAIN_EN`, q=0x00 without. Holding `out_ready`=0 for 5 cycles keeps q/cout/`out_valid` stable and `in_ready`=0.
- **Reset mid-shift:** op 8, b=0x07, `rst_n` pulsed low 3 cycles after accept → `out_valid`=0, q=0, cout=0 immediately. After release, `in_ready`=1 and the next op4 gives a correct result.
